// File: rtl/lc3b_types.sv
// Shared LC-3b types: memory-stage op encoding and access-controller state.
package lc3b_types;

   typedef enum logic [2:0] {
      MEM_NONE = 3'd0,
      MEM_LDW  = 3'd1,
      MEM_LDB  = 3'd2,
      MEM_STW  = 3'd3,
      MEM_STB  = 3'd4,
      MEM_LDI  = 3'd5,
      MEM_STI  = 3'd6
   } lc3b_mem_op;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS1 = 2'd1,
      ST_ACCESS2 = 2'd2,
      ST_DONE    = 2'd3
   } mem_access_state_t;

   function automatic logic is_indirect(input lc3b_mem_op op);
      return (op == MEM_LDI) || (op == MEM_STI);
   endfunction

   // Only direct stores write on the first access; STI reads its pointer first.
   function automatic logic is_first_write(input lc3b_mem_op op);
      return (op == MEM_STW) || (op == MEM_STB);
   endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering for stores and byte extraction/sign extension for loads.
module mem_byte_align
   import lc3b_types::*;
(
   input  lc3b_mem_op  op,
   input  logic        addr_lsb,
   input  logic [15:0] store_data,
   input  logic [15:0] load_word,
   output logic [15:0] store_lanes,
   output logic [1:0]  byte_enable,
   output logic [15:0] load_result
);

   logic [7:0] load_byte;

   always_comb begin
      store_lanes = store_data;
      byte_enable = 2'b11;
      load_result = load_word;
      load_byte   = addr_lsb ? load_word[15:8] : load_word[7:0];
      case (op)
         MEM_STB: begin
            store_lanes = {store_data[7:0], store_data[7:0]};
            byte_enable = addr_lsb ? 2'b10 : 2'b01;
            load_result = '0;
         end
         MEM_LDB: begin
            load_result = {{8{load_byte[7]}}, load_byte};
         end
         MEM_STW, MEM_STI: begin
            load_result = '0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/register.sv
// Generic load-enabled register with synchronous active-high clear.
module register #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-access controller: sequences direct and indirect cache
// accesses and stalls the pipeline until the access completes.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | waiting for a valid memory op; latches op/address/wdata
//  ST_ACCESS1 | first cache access (data, or pointer fetch for LDI/STI)
//  ST_ACCESS2 | second access at the fetched pointer (LDI read, STI write)
//  ST_DONE    | one-cycle completion; pipeline advances, no re-accept
module mem_access_unit
   import lc3b_types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  lc3b_mem_op  mem_op,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic        stall,
   output logic        done,
   output logic [15:0] rdata,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [1:0]  dmem_byte_enable,
   output logic [15:0] dmem_address,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_resp
);

   mem_access_state_t state;
   lc3b_mem_op        op_q;

   logic        request;
   logic        accept;
   logic        ptr_load;
   logic        result_load;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic [15:0] ptr_q;
   logic [15:0] result_q;
   logic [15:0] lane_wdata;
   logic [1:0]  lane_be;
   logic [15:0] load_result;

   assign request = mem_valid && (mem_op != MEM_NONE);
   assign stall   = request && (state != ST_DONE);
   assign accept  = (state == ST_IDLE) && request;

   assign ptr_load    = (state == ST_ACCESS1) && dmem_resp && is_indirect(op_q);
   assign result_load = dmem_resp &&
                        (((state == ST_ACCESS1) && !is_indirect(op_q)) ||
                         (state == ST_ACCESS2));

   register #(.WIDTH(16)) u_addr (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .d    (mem_address),
      .q    (addr_q)
   );

   register #(.WIDTH(16)) u_wdata (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .d    (mem_wdata),
      .q    (wdata_q)
   );

   register #(.WIDTH(16)) u_ptr (
      .clk  (clk),
      .rst  (rst),
      .load (ptr_load),
      .d    (dmem_rdata),
      .q    (ptr_q)
   );

   // LDI's second access is a plain word read and STI's yields zero, so the
   // same alignment output serves both access phases.
   register #(.WIDTH(16)) u_result (
      .clk  (clk),
      .rst  (rst),
      .load (result_load),
      .d    (load_result),
      .q    (result_q)
   );

   mem_byte_align u_align (
      .op          (op_q),
      .addr_lsb    (addr_q[0]),
      .store_data  (wdata_q),
      .load_word   (dmem_rdata),
      .store_lanes (lane_wdata),
      .byte_enable (lane_be),
      .load_result (load_result)
   );

   assign rdata = result_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         op_q  <= MEM_NONE;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (request) begin
                  op_q  <= mem_op;
                  state <= ST_ACCESS1;
               end
            end
            ST_ACCESS1: begin
               if (dmem_resp) begin
                  if (is_indirect(op_q)) begin
                     state <= ST_ACCESS2;
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_ACCESS2: begin
               if (dmem_resp) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Cache-side outputs decode only state and latched registers.
   always_comb begin
      dmem_read        = 1'b0;
      dmem_write       = 1'b0;
      dmem_byte_enable = 2'b00;
      dmem_address     = '0;
      dmem_wdata       = '0;
      case (state)
         ST_ACCESS1: begin
            dmem_address = {addr_q[15:1], 1'b0};
            if (is_first_write(op_q)) begin
               dmem_write       = 1'b1;
               dmem_wdata       = lane_wdata;
               dmem_byte_enable = lane_be;
            end else begin
               dmem_read        = 1'b1;
               dmem_byte_enable = 2'b11;
            end
         end
         ST_ACCESS2: begin
            dmem_address     = {ptr_q[15:1], 1'b0};
            dmem_byte_enable = 2'b11;
            if (op_q == MEM_STI) begin
               dmem_write = 1'b1;
               dmem_wdata = wdata_q;
            end else begin
               dmem_read = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
   import lc3b_types::*;

   logic        clk;
   logic        rst;
   logic        mem_valid;
   lc3b_mem_op  mem_op;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic        stall;
   logic        done;
   logic [15:0] rdata;
   logic        dmem_read;
   logic        dmem_write;
   logic [1:0]  dmem_byte_enable;
   logic [15:0] dmem_address;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        dmem_resp;

   int total = 0;
   int bad   = 0;

   mem_access_unit dut (
      .clk              (clk),
      .rst              (rst),
      .mem_valid        (mem_valid),
      .mem_op           (mem_op),
      .mem_address      (mem_address),
      .mem_wdata        (mem_wdata),
      .stall            (stall),
      .done             (done),
      .rdata            (rdata),
      .dmem_read        (dmem_read),
      .dmem_write       (dmem_write),
      .dmem_byte_enable (dmem_byte_enable),
      .dmem_address     (dmem_address),
      .dmem_wdata       (dmem_wdata),
      .dmem_rdata       (dmem_rdata),
      .dmem_resp        (dmem_resp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one cycle; inputs are driven and outputs sampled mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input lc3b_mem_op op, input logic [15:0] a, input logic [15:0] w);
      mem_valid   = 1'b1;
      mem_op      = op;
      mem_address = a;
      mem_wdata   = w;
   endtask

   task automatic drop();
      mem_valid   = 1'b0;
      mem_op      = MEM_NONE;
      mem_address = 16'h0;
      mem_wdata   = 16'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drop();
      dmem_resp  = 1'b0;
      dmem_rdata = 16'h0;
      tick();
      tick();
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
      total++; if ({dmem_read, dmem_write} !== 2'b00) begin bad++; $display("FAIL reset_req got=%b exp=00", {dmem_read, dmem_write}); end
      total++; if (dmem_address !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0000", dmem_address); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_ldw();
      request(MEM_LDW, 16'h3001, 16'h0);
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL ldw_c0_stall got=%b exp=1", stall); end
      total++; if (dmem_read !== 1'b0) begin bad++; $display("FAIL ldw_c0_read got=%b exp=0", dmem_read); end
      tick();
      dmem_resp  = 1'b1;
      dmem_rdata = 16'hBEEF;
      #1;
      total++; if (dmem_read !== 1'b1) begin bad++; $display("FAIL ldw_c1_read got=%b exp=1", dmem_read); end
      total++; if (dmem_address !== 16'h3000) begin bad++; $display("FAIL ldw_c1_addr got=%h exp=3000", dmem_address); end
      total++; if (dmem_byte_enable !== 2'b11) begin bad++; $display("FAIL ldw_c1_be got=%b exp=11", dmem_byte_enable); end
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL ldw_c1_stall got=%b exp=1", stall); end
      tick();
      dmem_resp  = 1'b0;
      dmem_rdata = 16'h0;
      #1;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL ldw_c2_done got=%b exp=1", done); end
      total++; if (rdata !== 16'hBEEF) begin bad++; $display("FAIL ldw_c2_rdata got=%h exp=beef", rdata); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL ldw_c2_stall got=%b exp=0", stall); end
      total++; if (dmem_read !== 1'b0) begin bad++; $display("FAIL ldw_c2_read got=%b exp=0", dmem_read); end
      tick();
      drop();
      #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL ldw_c3_done got=%b exp=0", done); end
      tick();
   endtask

   task automatic test_stb_slow();
      int done_cnt = 0;
      request(MEM_STB, 16'h4001, 16'h12A5);
      tick();
      for (int i = 0; i < 4; i++) begin
         dmem_resp = (i == 3);
         #1;
         if (done) done_cnt++;
         total++; if (dmem_write !== 1'b1 || dmem_read !== 1'b0) begin bad++; $display("FAIL stb_write[%0d] got=%b%b exp=01", i, dmem_read, dmem_write); end
         total++; if (dmem_wdata !== 16'hA5A5) begin bad++; $display("FAIL stb_wdata[%0d] got=%h exp=a5a5", i, dmem_wdata); end
         total++; if (dmem_byte_enable !== 2'b10) begin bad++; $display("FAIL stb_be[%0d] got=%b exp=10", i, dmem_byte_enable); end
         total++; if (dmem_address !== 16'h4000) begin bad++; $display("FAIL stb_addr[%0d] got=%h exp=4000", i, dmem_address); end
         total++; if (stall !== 1'b1) begin bad++; $display("FAIL stb_stall[%0d] got=%b exp=1", i, stall); end
         tick();
      end
      dmem_resp = 1'b0;
      #1;
      if (done) done_cnt++;
      total++; if (rdata !== 16'h0) begin bad++; $display("FAIL stb_rdata got=%h exp=0000", rdata); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL stb_done_stall got=%b exp=0", stall); end
      tick();
      drop();
      #1;
      if (done) done_cnt++;
      tick();
      if (done) done_cnt++;
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL stb_done_pulses got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_ldb();
      logic [15:0] addrs [2] = '{16'h2000, 16'h2001};
      logic [15:0] exps  [2] = '{16'h007F, 16'hFF80};
      for (int i = 0; i < 2; i++) begin
         request(MEM_LDB, addrs[i], 16'h0);
         tick();
         dmem_resp  = 1'b1;
         dmem_rdata = 16'h807F;
         #1;
         total++; if (dmem_address !== 16'h2000) begin bad++; $display("FAIL ldb_addr[%0d] got=%h exp=2000", i, dmem_address); end
         tick();
         dmem_resp  = 1'b0;
         dmem_rdata = 16'h0;
         #1;
         total++; if (done !== 1'b1 || rdata !== exps[i]) begin bad++; $display("FAIL ldb_result[%0d] got=%b/%h exp=1/%h", i, done, rdata, exps[i]); end
         tick();
         drop();
         tick();
      end
   endtask

   task automatic test_ldi();
      request(MEM_LDI, 16'h1000, 16'h0);
      tick();
      dmem_resp  = 1'b1;
      dmem_rdata = 16'h5003;
      #1;
      total++; if (dmem_read !== 1'b1 || dmem_address !== 16'h1000) begin bad++; $display("FAIL ldi_c1 got=%b/%h exp=1/1000", dmem_read, dmem_address); end
      tick();
      dmem_rdata = 16'h1234;
      #1;
      total++; if (dmem_read !== 1'b1 || dmem_address !== 16'h5002) begin bad++; $display("FAIL ldi_c2 got=%b/%h exp=1/5002", dmem_read, dmem_address); end
      total++; if (stall !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL ldi_c2_ctl got=%b%b exp=10", stall, done); end
      tick();
      dmem_resp  = 1'b0;
      dmem_rdata = 16'h0;
      #1;
      total++; if (done !== 1'b1 || rdata !== 16'h1234) begin bad++; $display("FAIL ldi_c3 got=%b/%h exp=1/1234", done, rdata); end
      tick();
      drop();
      tick();
   endtask

   task automatic test_sti_reset();
      request(MEM_STI, 16'h0800, 16'hCAFE);
      tick();
      dmem_resp  = 1'b1;
      dmem_rdata = 16'h6001;
      #1;
      total++; if ({dmem_read, dmem_write} !== 2'b10) begin bad++; $display("FAIL sti_ptr_read got=%b exp=10", {dmem_read, dmem_write}); end
      tick();
      dmem_resp  = 1'b0;
      dmem_rdata = 16'h0;
      #1;
      total++; if ({dmem_read, dmem_write} !== 2'b01) begin bad++; $display("FAIL sti_write got=%b exp=01", {dmem_read, dmem_write}); end
      total++; if (dmem_address !== 16'h6000 || dmem_byte_enable !== 2'b11) begin bad++; $display("FAIL sti_addr_be got=%h/%b exp=6000/11", dmem_address, dmem_byte_enable); end
      total++; if (dmem_wdata !== 16'hCAFE) begin bad++; $display("FAIL sti_wdata got=%h exp=cafe", dmem_wdata); end
      rst = 1'b1;
      drop();
      tick();
      #1;
      total++; if (dmem_write !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL sti_rst got=w%b s%b d%b exp=w0 s0 d0", dmem_write, stall, done); end
      rst = 1'b0;
      tick();
      total++; if (done !== 1'b0 || dmem_read !== 1'b0) begin bad++; $display("FAIL sti_post_rst got=d%b r%b exp=d0 r0", done, dmem_read); end
   endtask

   task automatic test_stray();
      request(MEM_NONE, 16'h7777, 16'h1111);
      dmem_resp  = 1'b1;
      dmem_rdata = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (stall !== 1'b0 || {dmem_read, dmem_write} !== 2'b00 || done !== 1'b0 || dmem_address !== 16'h0) begin bad++; $display("FAIL stray[%0d] got=s%b rw%b%b d%b a%h exp=s0 rw00 d0 a0000", i, stall, dmem_read, dmem_write, done, dmem_address); end
         tick();
      end
      dmem_resp = 1'b0;
      request(MEM_LDW, 16'h0002, 16'h0);
      tick();
      dmem_resp  = 1'b1;
      dmem_rdata = 16'h4242;
      #1;
      total++; if (done !== 1'b0 || dmem_read !== 1'b1) begin bad++; $display("FAIL stray_then_ldw_c1 got=d%b r%b exp=d0 r1", done, dmem_read); end
      tick();
      dmem_resp = 1'b0;
      #1;
      total++; if (done !== 1'b1 || rdata !== 16'h4242) begin bad++; $display("FAIL stray_then_ldw_c2 got=%b/%h exp=1/4242", done, rdata); end
      tick();
      drop();
      tick();
   endtask

   task automatic test_back_to_back();
      request(MEM_STW, 16'h0011, 16'h5555);
      tick();
      dmem_resp = 1'b1;
      #1;
      total++; if (dmem_write !== 1'b1 || dmem_wdata !== 16'h5555 || dmem_byte_enable !== 2'b11 || dmem_address !== 16'h0010) begin bad++; $display("FAIL b2b_stw got=w%b %h %b %h exp=w1 5555 11 0010", dmem_write, dmem_wdata, dmem_byte_enable, dmem_address); end
      tick();
      dmem_resp = 1'b0;
      #1;
      total++; if (done !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL b2b_done got=d%b s%b exp=d1 s0", done, stall); end
      tick();
      request(MEM_LDW, 16'h0020, 16'h0);
      #1;
      total++; if (stall !== 1'b1 || dmem_write !== 1'b0) begin bad++; $display("FAIL b2b_accept got=s%b w%b exp=s1 w0", stall, dmem_write); end
      tick();
      #1;
      total++; if (dmem_read !== 1'b1 || dmem_address !== 16'h0020) begin bad++; $display("FAIL b2b_ldw got=r%b %h exp=r1 0020", dmem_read, dmem_address); end
      dmem_resp  = 1'b1;
      dmem_rdata = 16'h0BAD;
      tick();
      dmem_resp = 1'b0;
      #1;
      total++; if (done !== 1'b1 || rdata !== 16'h0BAD) begin bad++; $display("FAIL b2b_ldw_done got=%b/%h exp=1/0bad", done, rdata); end
      tick();
      drop();
      tick();
   endtask

   initial begin
      rst         = 1'b1;
      mem_valid   = 1'b0;
      mem_op      = MEM_NONE;
      mem_address = 16'h0;
      mem_wdata   = 16'h0;
      dmem_rdata  = 16'h0;
      dmem_resp   = 1'b0;
      test_reset();
      test_ldw();
      test_stb_slow();
      test_ldb();
      test_ldi();
      test_sti_reset();
      test_stray();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-access controller for the pipelined LC-3b datapath. It consumes the EX/MEM pipeline outputs (valid, memory op, effective address, store data) and acts as the initiator toward the data cache. It sequences single and double (indirect) accesses, steers byte lanes, and holds a pipeline stall until load data or store completion is ready for the MEM/WB register.

## Interface

Parameters: none (widths fixed by `lc3b_types`).

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `mem_valid`  in  1  instruction in MEM stage is valid
- `mem_op`  in  `lc3b_mem_op`  NONE, LDW, LDB, STW, STB, LDI, STI
- `mem_address`  in  16  effective byte address
- `mem_wdata`  in  16  store source (SR) value
- `stall`  out  1  hold all upstream pipeline registers
- `done`  out  1  one-cycle pulse: access sequence complete
- `rdata`  out  16  load result; valid while `done`=1
- `dmem_read`  out  1  cache read request
- `dmem_write`  out  1  cache write request
- `dmem_byte_enable`  out  2  lane enables {hi, lo}
- `dmem_address`  out  16  word address, bit 0 always 0
- `dmem_wdata`  out  16  write data
- `dmem_rdata`  in  16  cache read data
- `dmem_resp`  in  1  cache response, one cycle per request

## Operation

- States: IDLE, ACCESS1, ACCESS2, DONE.
- **IDLE:** a request is `mem_valid`=1 and `mem_op`≠NONE. On a request, latch op, address and wdata, then go to ACCESS1. Otherwise remain in IDLE.
- **ACCESS1:** assert `dmem_read` for loads, LDI and STI, or `dmem_write` for STW and STB. The request stays held until `dmem_resp`.
  - On resp with LDI or STI: latch `dmem_rdata` as the pointer, then go to ACCESS2.
  - On resp with any other op: latch the load result, then go to DONE.
- **ACCESS2:** access the pointer word address with a read for LDI or a write for STI. On resp, go to DONE; LDI latches its result.
- **DONE:** `done`=1 for one cycle, then go to IDLE. The request still present on the inputs this cycle is not re-accepted.
- **`stall`:** combinational, equal to (request present AND state≠DONE). It is 0 in DONE so the pipeline advances at that edge.
- **Word ops** (LDW, STW, LDI, STI, and the pointer access):
  - `dmem_address` = {addr[15:1],0}.
  - `dmem_byte_enable` = 2'b11.
  - Misaligned bit 0 is ignored.
- **Byte store (STB):**
  - `dmem_wdata` = {wdata[7:0], wdata[7:0]}.
  - `dmem_byte_enable` = addr[0] ? 2'b10 : 2'b01.
- **Byte load (LDB):** result = SEXT(addr[0] ? rdata[15:8] : rdata[7:0]).
- **Stores:** `rdata` = 0.
- **Idle outputs:** in IDLE and DONE, `dmem_read` = `dmem_write` = 0, and `dmem_address`, `dmem_wdata` and `dmem_byte_enable` = 0.
- **Stray responses:** `dmem_resp` outside ACCESS1 or ACCESS2 is ignored.

## Timing

- **Reset:** state IDLE, `done`=0, `rdata`=0, and latched registers = 0. `rst` has priority over all transitions, including mid-access: IDLE at the next edge, and requests drop that edge.
- **Minimum latency, single access:** request at cycle 0, request asserted at cycle 1, resp at cycle 1, DONE at cycle 2. `stall` is high in cycles 0–1.
- **Minimum latency, indirect:** DONE at cycle 3.
- **Slow cache:** each cycle without `dmem_resp` adds one stall cycle.
- **Input stability:** upstream holds inputs stable while `stall`=1. The unit still uses only the latched copies after IDLE.
- **Back-to-back requests:** a new request is accepted no earlier than the cycle after DONE, so consecutive memory ops have no bubble beyond the DONE cycle.
- **Output registration:** `dmem_*` outputs are state-decoded from registered values and have no combinational path from `dmem_rdata`.

## Structure

- **`lc3b_types`:** add `lc3b_mem_op` (3-bit enum) and `mem_access_state_t`.
- **`mem_byte_align`:** one combinational sub-module for store lane replication and enable generation, plus load byte extraction and sign extension.
- **Top level:** holds the FSM and latches, and instantiates the existing `register` for the latched address, wdata, pointer and result.

## Test plan

- LDW at 0x3001, cache returns 0xBEEF with resp on the first request cycle: `dmem_address`=0x3000, be=11. DONE at cycle 2 with `rdata`=0xBEEF; `stall` high for exactly cycles 0–1.
- STB at 0x4001 with wdata 0x12A5: `dmem_wdata`=0xA5A5, be=10, write held across a 3-cycle resp delay. `stall` spans all wait cycles and `done` pulses once.
- LDB at 0x2000 and at 0x2001 with cache word 0x80_7F: results 0x007F and 0xFF80 respectively.
- LDI at 0x1000 where mem[0x1000]=0x5003 and mem[0x5002]=0x1234: read 0x1000, then read 0x5002. `rdata`=0x1234 at cycle 3.
- STI: pointer read followed by a write at the pointer with be=11. Assert `rst` during ACCESS2: next cycle IDLE, `dmem_write`=0, `stall`=0, and no `done`.
- Stray `dmem_resp` in IDLE and `mem_op`=NONE with `mem_valid`=1: no state change, `stall`=0, no requests issued.
